// File: rtl/proc_req_gen_if.sv
// Processor request port: the request generator drives requests (master),
// the cache controller accepts them and returns responses (slave).
interface proc_req_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, rvalid, rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, rvalid, rdata
    );
endinterface

// File: rtl/proc_req_gen.sv
// Processor-side request generator: sequential/strided/LFSR-random addresses inside a window,
// one outstanding request, response count and checksum. Optional write mix: PROC_WRITE_MIX_EN.
module proc_req_gen #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          WORD_BYTES = 4,
    parameter int          WIN_BYTES  = 128,
    parameter int          CNT_W      = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     stride,
    input  logic [CNT_W-1:0]      num_req,
    proc_req_gen_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      resp_count,
    output logic [DATA_W-1:0]     checksum
);
    localparam logic [ADDR_W-1:0] WIN_MASK   = ADDR_W'(WIN_BYTES - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_BYTES - 1));
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state_reg;
    logic [1:0]          mode_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W-1:0]   stride_reg;
    logic [CNT_W-1:0]    num_reg;
    logic [CNT_W-1:0]    issued_reg;
    logic [ADDR_W-1:0]   offset_reg;
    logic [15:0]         lfsr_reg;
    logic                req_valid_reg;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic                req_we_reg;
    logic [DATA_W-1:0]   req_wdata_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [CNT_W-1:0]    resp_count_reg;
    logic [DATA_W-1:0]   checksum_reg;

    logic [15:0]         lfsr_next;
    logic [ADDR_W-1:0]   rand_off;
    logic [ADDR_W-1:0]   offset_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                we_next;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    // Zero-extend (or truncate) the LFSR state to address width
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_rand_off
        if (gi < 16) begin : g_lfsr_bit
            assign rand_off[gi] = lfsr_reg[gi];
        end else begin : g_zero_bit
            assign rand_off[gi] = 1'b0;
        end
    end

    always_comb begin
        offset_next = '0;
        case (mode_reg)
            2'b01:   offset_next = offset_reg + (stride_reg & ALIGN_MASK);
            2'b10:   offset_next = rand_off;
            default: offset_next = offset_reg + WORD_STEP;
        endcase
        offset_next = offset_next & WIN_MASK & ALIGN_MASK;
    end

    assign addr_next = base_reg + offset_next;

    // In WAIT, issued_reg already equals the index of the request about to be loaded
`ifdef PROC_WRITE_MIX_EN
    assign we_next = (issued_reg[1:0] == 2'b11);
`else
    assign we_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mode_reg       <= 2'b00;
            base_reg       <= '0;
            stride_reg     <= '0;
            num_reg        <= '0;
            issued_reg     <= '0;
            offset_reg     <= '0;
            lfsr_reg       <= LFSR_SEED;
            req_valid_reg  <= 1'b0;
            req_addr_reg   <= '0;
            req_we_reg     <= 1'b0;
            req_wdata_reg  <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            resp_count_reg <= '0;
            checksum_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg       <= mode;
                        base_reg       <= base_addr;
                        stride_reg     <= stride;
                        num_reg        <= num_req;
                        issued_reg     <= '0;
                        offset_reg     <= '0;
                        lfsr_reg       <= LFSR_SEED;
                        resp_count_reg <= '0;
                        checksum_reg   <= '0;
                        busy_reg       <= 1'b1;
                        if (num_req == '0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg     <= REQ;
                            req_valid_reg <= 1'b1;
                            req_addr_reg  <= base_addr;
                            req_we_reg    <= 1'b0;
                            req_wdata_reg <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus.req_ready) begin
                        req_valid_reg <= 1'b0;
                        issued_reg    <= issued_reg + CNT_ONE;
                        lfsr_reg      <= lfsr_next;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.rvalid) begin
                        resp_count_reg <= resp_count_reg + CNT_ONE;
                        // Write acknowledges carry no read data
                        if (!req_we_reg) begin
                            checksum_reg <= checksum_reg + bus.rdata;
                        end
                        if (issued_reg == num_reg) begin
                            state_reg <= DONE;
                        end else begin
                            offset_reg    <= offset_next;
                            req_addr_reg  <= addr_next;
                            req_we_reg    <= we_next;
                            req_wdata_reg <= we_next ? DATA_W'(addr_next) : '0;
                            req_valid_reg <= 1'b1;
                            state_reg     <= REQ;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_valid = req_valid_reg;
    assign bus.req_addr  = req_addr_reg;
    assign bus.req_we    = req_we_reg;
    assign bus.req_wdata = req_wdata_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign resp_count    = resp_count_reg;
    assign checksum      = checksum_reg;
endmodule

// File: tb/tb_proc_req_gen.sv
// Self-checking bench for proc_req_gen: randomized runs against a queue-based address/response model.
module tb_proc_req_gen;
`ifdef PROC_WRITE_MIX_EN
    localparam bit WRITE_MIX = 1'b1;
`else
    localparam bit WRITE_MIX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [15:0] num_req = '0;
    logic        busy;
    logic        done;
    logic [15:0] resp_count;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    proc_req_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    proc_req_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .stride     (stride),
        .num_req    (num_req),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .resp_count (resp_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Polynomial x^16 + x^14 + x^13 + x^11 + 1: feedback is the XOR of the state bits at exponents 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int exps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (exps[k]) fb = fb ^ v[exps[k] - 1];
        return {v[14:0], fb};
    endfunction

    task automatic run_cfg(input string name, input logic [1:0] m, input logic [31:0] b,
                           input logic [31:0] s, input int n, input int stall_req,
                           input int stall_len, input bit rand_ready, input bit poke_start);
        logic [31:0] exp_addr[$];
        bit          exp_we[$];
        logic [31:0] got_addr[$];
        bit          got_we[$];
        logic [31:0] off, exp_sum, rd, prev_addr;
        logic [15:0] lf;
        int          cyc, dones, post, stall_cnt, delay, budget, idx;
        bit          pending, pend_we, prev_stall, seen_done;

        off = '0;
        lf  = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(b + off);
            exp_we.push_back(WRITE_MIX && (i % 4 == 3));
            lf = lfsr_step(lf);
            case (m)
                2'b01:   off = (off + (s & ~32'h3)) % 128;
                2'b10:   off = ({16'h0, lf} % 128) & ~32'h3;
                default: off = (off + 4) % 128;
            endcase
        end

        @(negedge clk);
        mode = m; base_addr = b; stride = s; num_req = 16'(n); start = 1'b1;
        @(negedge clk);
        cyc = 0; dones = 0; post = 0; seen_done = 0; pending = 0; pend_we = 0;
        stall_cnt = 0; prev_stall = 0; prev_addr = '0; exp_sum = '0; delay = 0; rd = '0;
        budget = 40 + n * 12;
        while (post < 3 && cyc < budget) begin
            start = 1'b0;
            bus.rvalid = 1'b0;
            bus.req_ready = 1'b0;
            if (done === 1'b1) begin
                dones++;
                seen_done = 1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
                end
            end
            if (seen_done) post++;
            if (pending) begin
                if (delay == 0) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = rd;
                    if (!pend_we) exp_sum = exp_sum + rd;
                    pending = 0;
                end else begin
                    delay--;
                end
            end
            if (bus.req_valid === 1'b1) begin
                checks++;
                if (busy !== 1'b1 || seen_done) begin
                    errors++;
                    $display("FAIL %s valid_busy: busy=%b done_seen=%0d expected busy=1 before done", name, busy, seen_done);
                end
                if (prev_stall) begin
                    checks++;
                    if (bus.req_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL %s hold_addr: got %h expected %h", name, bus.req_addr, prev_addr);
                    end
                end
                if (got_addr.size() == stall_req && stall_cnt < stall_len) begin
                    bus.req_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bus.req_ready) begin
                    idx = got_addr.size();
                    got_addr.push_back(bus.req_addr);
                    got_we.push_back(bus.req_we);
                    pending = 1;
                    pend_we = (idx < n) ? exp_we[idx] : 1'b0;
                    delay   = rand_ready ? $urandom_range(0, 2) : 0;
                    rd      = rand_ready ? 32'($urandom) : ((idx < n) ? exp_addr[idx] : 32'h0);
                end else if ($urandom_range(0, 2) == 0) begin
                    // Response outside WAIT must be ignored
                    bus.rvalid = 1'b1;
                    bus.rdata  = 32'($urandom);
                end
                prev_stall = !bus.req_ready;
                prev_addr  = bus.req_addr;
            end else begin
                prev_stall = 0;
            end
            if (poke_start && cyc == 2) begin
                start = 1'b1;
                mode = m ^ 2'b11;
                base_addr = b + 32'h100;
                num_req = 16'(n + 5);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.rvalid = 1'b0;
        bus.req_ready = 1'b0;

        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, budget);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, dones);
        end
        checks++;
        if (got_addr.size() != n) begin
            errors++;
            $display("FAIL %s issued: got %0d expected %0d", name, got_addr.size(), n);
        end
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            $display("%s req %0d addr=%h we=%0b", name, i, got_addr[i], got_we[i]);
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_we[i] !== exp_we[i]) begin
                errors++;
                $display("FAIL %s req%0d: got addr=%h we=%0b expected addr=%h we=%0b",
                         name, i, got_addr[i], got_we[i], exp_addr[i], exp_we[i]);
            end
        end
        checks++;
        if (resp_count !== 16'(n)) begin
            errors++;
            $display("FAIL %s resp_count: got %0d expected %0d", name, resp_count, n);
        end
        checks++;
        if (checksum !== exp_sum) begin
            errors++;
            $display("FAIL %s checksum: got %h expected %h", name, checksum, exp_sum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_valid !== 1'b0 || bus.req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: got valid=%b addr=%h expected 0/0", bus.req_valid, bus.req_addr);
        end
        checks++;
        if (bus.req_we !== 1'b0 || bus.req_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_wr: got we=%b wdata=%h expected 0/0", bus.req_we, bus.req_wdata);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b expected 0/0", busy, done);
        end
        checks++;
        if (resp_count !== 16'h0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: got cnt=%0d sum=%h expected 0/0", resp_count, checksum);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequential();
        run_cfg("sequential", 2'b00, 32'h0000_1000, 32'h0, 34, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_cfg("backpressure", 2'b00, 32'h0000_1000, 32'h0, 4, 1, 5, 1'b0, 1'b0);
    endtask

    task automatic test_strided();
        run_cfg("strided", 2'b01, 32'h0, 32'h26, 5, -1, 0, 1'b0, 1'b0);
        run_cfg("stride0", 2'b01, 32'h0000_0500, 32'h3, 3, -1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        run_cfg("random", 2'b10, 32'h0000_3000, 32'h0, 4, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_zero();
        @(negedge clk);
        mode = 2'b00; num_req = 16'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || bus.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_c1: got done=%b busy=%b valid=%b expected 0/1/0", done, busy, bus.req_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_c2: got done=%b busy=%b valid=%b expected 1/0/0", done, busy, bus.req_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || resp_count !== 16'h0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL zero_c3: got done=%b cnt=%0d sum=%h expected 0/0/0", done, resp_count, checksum);
        end
    endtask

    task automatic test_write_mix();
        run_cfg("write_mix", 2'b00, 32'h0000_4000, 32'h0, 8, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mode = 2'b00; base_addr = 32'h0000_2000; num_req = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.req_ready = 1'b1;
        checks++;
        if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL midrst_req1: got valid=%b addr=%h expected 1/00002000", bus.req_valid, bus.req_addr);
        end
        @(negedge clk);
        bus.req_ready = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_0011;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.req_ready = 1'b1;
        checks++;
        if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0000_2004 || resp_count !== 16'd1) begin
            errors++;
            $display("FAIL midrst_req2: got valid=%b addr=%h cnt=%0d expected 1/00002004/1",
                     bus.req_valid, bus.req_addr, resp_count);
        end
        @(negedge clk);
        bus.req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req_valid !== 1'b0 || bus.req_addr !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
            resp_count !== 16'h0 || checksum !== 32'h0 || bus.req_we !== 1'b0 || bus.req_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async: got valid=%b addr=%h busy=%b cnt=%0d sum=%h expected all 0",
                     bus.req_valid, bus.req_addr, busy, resp_count, checksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_0055;
        @(negedge clk);
        bus.rvalid = 1'b0;
        checks++;
        if (resp_count !== 16'h0 || checksum !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale: got cnt=%0d sum=%h busy=%b expected 0/0/0", resp_count, checksum, busy);
        end
        run_cfg("after_reset", 2'b00, 32'h0, 32'h0, 2, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_configs();
        run_cfg("addr_wrap", 2'b00, 32'hFFFF_FFF0, 32'h0, 8, -1, 0, 1'b0, 1'b0);
        run_cfg("mode3", 2'b11, 32'h0000_8000, 32'h44, 6, -1, 0, 1'b1, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_cfg($sformatf("rand%0d", t), 2'($urandom_range(0, 3)), 32'($urandom),
                    32'($urandom_range(0, 255)), $urandom_range(1, 20),
                    $urandom_range(0, 4), $urandom_range(0, 4), 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_strided();
        test_random();
        test_zero();
        test_write_mix();
        test_reset_mid();
        test_random_configs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_req_gen.md
Name: proc_req_gen

Overview:
- Parametrised processor-side request generator that drives the cache controller's request port.
- Successor to the fixed step-of-4, wrap-at-124 address stepper. Adds:
  - start/done control
  - valid/ready request handshake
  - configurable base, window, stride and count
  - sequential, strided and pseudo-random address modes
  - a response checksum for self-checking benches.
- Sits between the testbench/top-level control and the cache controller's processor interface.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, read/write data width
WORD_BYTES, 4, bytes per word; power of two; sequential step
WIN_BYTES, 128, address window size; power of two, >= WORD_BYTES; offsets wrap modulo this
CNT_W, 16, width of num_req and resp_count
LFSR_SEED, 16'hACE1, non-zero reset/start value of the 16-bit LFSR

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse; begins a run when idle
mode  input  2  00 sequential, 01 strided, 10 random, 11 treated as 00
base_addr  input  ADDR_W  window base; latched at start
stride  input  ADDR_W  byte stride for mode 01; latched at start
num_req  input  CNT_W  requests in run; latched at start
req_valid  output  1  request valid
req_ready  input  1  controller accepts request
req_addr  output  ADDR_W  request address
req_we  output  1  write enable (0 unless optional feature)
req_wdata  output  DATA_W  write data (0 unless optional feature)
rvalid  input  1  response valid from controller
rdata  input  DATA_W  response data
busy  output  1  run in progress
done  output  1  1-cycle pulse at end of run
resp_count  output  CNT_W  responses received this run
checksum  output  DATA_W  running sum of rdata, modulo 2^DATA_W

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; lfsr=LFSR_SEED.
  - All outputs 0: req_valid, req_addr, req_we, req_wdata, busy, done, resp_count, checksum.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start, latch mode/base/stride/num_req.
  - Clear offset, resp_count, checksum and issued count; reload lfsr=LFSR_SEED.
  - If num_req==0 go DONE, else go REQ.
  - busy=1 from the cycle after start until DONE exits.
- REQ:
  - req_valid=1; req_addr=base+offset. Addition truncated to ADDR_W, so wrap at the top of the address space is permitted.
  - req_addr/req_we/req_wdata are held stable while req_valid=1 and req_ready=0.
  - On req_valid&&req_ready: issued+1, go WAIT; req_valid drops next cycle.
- WAIT:
  - req_valid=0.
  - On rvalid: checksum+=rdata, resp_count+=1.
  - Then if issued==num_req go DONE. Otherwise compute the next offset and go REQ; req_valid reasserts the next cycle.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Next offset rules (all results ANDed with WIN_BYTES-1 and WORD_BYTES-aligned):
  - mode 00: offset+WORD_BYTES, e.g. WIN 128 gives 0,4,...,124,0.
  - mode 01: offset+(stride with low log2(WORD_BYTES) bits cleared). Stride 0 repeats the same address.
  - mode 10: LFSR advances once per accepted request (x^16+x^14+x^13+x^11+1, Fibonacci, shift left). Offset = new lfsr value masked and aligned. The first request uses offset 0.
- rvalid outside WAIT is ignored: no count or checksum change. The controller responds at least 1 cycle after acceptance.
- start while busy is ignored; the latched configuration does not change mid-run.
- Reset mid-run aborts immediately to IDLE with reset values. Any outstanding response after reset is ignored.
- resp_count and checksum hold their final values in IDLE until the next start.

Optional Feature:
- PROC_WRITE_MIX_EN defined:
  - Every 4th issued request (issued index 3,7,11,...) has req_we=1 and req_wdata = req_addr zero-extended/truncated to DATA_W.
  - Its write acknowledge (rvalid) increments resp_count but does not add to checksum.
- Undefined: req_we and req_wdata are tied to 0; all requests are reads.

Test Plan:
- Reset mid-stream: assert rst_n=0 during WAIT -> all outputs 0 asynchronously; a subsequent rvalid is ignored; a new start with base 0 restarts at addr 0.
- Sequential: base 0x1000, num_req 34, ready always 1, rvalid 1 cycle after accept, rdata=addr -> addrs 0x1000..0x107C then 0x1000,0x1004. resp_count 34, checksum = sum of issued addrs, single done pulse.
- Backpressure: mode 00, req_ready low for 5 cycles on request 2 -> req_addr stays 0x1004 and req_valid stays 1 throughout; no duplicate issue.
- Strided: mode 01, base 0, stride 0x26 (aligned to 0x24), num_req 5 -> addrs 0x00,0x24,0x48,0x6C,0x10.
- Random: mode 10, num_req 4 -> first addr = base; next three match the reference LFSR model masked to 0x7C; start pulsed while busy has no effect.
- num_req 0 -> done pulses 2 cycles after start, no req_valid, resp_count 0. With PROC_WRITE_MIX_EN and num_req 8: req_we=1 only on requests 4 and 8.
